// File: rtl/home_cell_sweep_ctrl.sv
// Home-cell sweep sequencer: reads the particle count from address 0, then for each
// reference particle streams two passes (phase 0, phase 1) over addresses 1..N.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; memory read disabled
// READ_NUM | address 0 issued to fetch particle count N
// WAIT_NUM | count data on the bus; latch N, pick SWEEP or DONE
// SWEEP    | issuing addresses 1..N, two phases per reference particle
// DONE     | sweep finished; next cycle pulses done and drops busy
module home_cell_sweep_ctrl #(
    parameter int PARTICLE_ID_WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stall,
    input  logic [PARTICLE_ID_WIDTH-1:0] count_data,
    output logic [PARTICLE_ID_WIDTH-1:0] mem_rd_addr,
    output logic                         mem_rd_en,
    output logic                         reading_particle_num,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic                         phase,
    output logic                         prev_phase,
    output logic                         particle_valid,
    output logic                         busy,
    output logic                         done
);

    localparam logic [PARTICLE_ID_WIDTH-1:0] ID_ZERO = '0;
    localparam logic [PARTICLE_ID_WIDTH-1:0] ID_ONE  = PARTICLE_ID_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ_NUM = 3'd1,
        S_WAIT_NUM = 3'd2,
        S_SWEEP    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                         state_q;
    logic [PARTICLE_ID_WIDTH-1:0]   num_q;
    logic [PARTICLE_ID_WIDTH-1:0]   addr_q;
    logic                           rd_en_q;
    logic                           sweep_phase_q;
    logic [PARTICLE_ID_WIDTH-1:0]   sweep_ref_q;
    logic                           rpn_q;
    logic [PARTICLE_ID_WIDTH-1:0]   particle_id_q;
    logic [PARTICLE_ID_WIDTH-1:0]   ref_id_q;
    logic                           phase_q;
    logic                           prev_phase_q;
    logic                           valid_q;
    logic                           busy_q;
    logic                           done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            num_q         <= ID_ZERO;
            addr_q        <= ID_ZERO;
            rd_en_q       <= 1'b0;
            sweep_phase_q <= 1'b0;
            sweep_ref_q   <= ID_ZERO;
            rpn_q         <= 1'b0;
            particle_id_q <= ID_ZERO;
            ref_id_q      <= ID_ZERO;
            phase_q       <= 1'b0;
            prev_phase_q  <= 1'b0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            rpn_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q       <= S_READ_NUM;
                        busy_q        <= 1'b1;
                        rd_en_q       <= 1'b1;
                        addr_q        <= ID_ZERO;
                        particle_id_q <= ID_ZERO;
                        ref_id_q      <= ID_ZERO;
                        // fresh sweep: ref 1's first beat must not look like a reference change
                        phase_q       <= 1'b0;
                        prev_phase_q  <= 1'b0;
                    end
                end
                S_READ_NUM: begin
                    state_q <= S_WAIT_NUM;
                    rd_en_q <= 1'b0;
                    rpn_q   <= 1'b1;
                end
                S_WAIT_NUM: begin
                    num_q <= count_data;
                    if (count_data == ID_ZERO) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q       <= S_SWEEP;
                        rd_en_q       <= 1'b1;
                        addr_q        <= ID_ONE;
                        sweep_phase_q <= 1'b0;
                        sweep_ref_q   <= ID_ONE;
                        ref_id_q      <= ID_ONE;
                    end
                end
                S_SWEEP: begin
                    if (!stall) begin
                        valid_q       <= 1'b1;
                        particle_id_q <= addr_q;
                        phase_q       <= sweep_phase_q;
                        prev_phase_q  <= phase_q;
                        ref_id_q      <= sweep_ref_q;
                        if (addr_q == num_q) begin
                            addr_q <= ID_ONE;
                            if (!sweep_phase_q) begin
                                sweep_phase_q <= 1'b1;
                            end else if (sweep_ref_q == num_q) begin
                                state_q <= S_DONE;
                                rd_en_q <= 1'b0;
                                addr_q  <= ID_ZERO;
                            end else begin
                                sweep_phase_q <= 1'b0;
                                sweep_ref_q   <= sweep_ref_q + ID_ONE;
                            end
                        end else begin
                            addr_q <= addr_q + ID_ONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_addr          = addr_q;
    assign mem_rd_en            = rd_en_q;
    assign reading_particle_num = rpn_q;
    assign particle_id          = particle_id_q;
    assign ref_id               = ref_id_q;
    assign phase                = phase_q;
    assign prev_phase           = prev_phase_q;
    assign particle_valid       = valid_q;
    assign busy                 = busy_q;
    assign done                 = done_q;

endmodule

// File: doc/home_cell_sweep_ctrl.md
HOME_CELL_SWEEP_CTRL -- requirements
Module: home_cell_sweep_ctrl

Interface
REQ-001 SHALL have parameter PARTICLE_ID_WIDTH, default 7, the width of particle/reference IDs and home-cell memory addresses.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a home-cell sweep.
REQ-005 SHALL have port stall  input  1  downstream backpressure; when high, no address is accepted this cycle.
REQ-006 SHALL have port count_data  input  PARTICLE_ID_WIDTH  low bits of memory x-word read data (particle count when address 0 is read).
REQ-007 SHALL have port mem_rd_addr  output  PARTICLE_ID_WIDTH  home-cell position memory read address.
REQ-008 SHALL have port mem_rd_en  output  1  memory read enable.
REQ-009 SHALL have port reading_particle_num  output  1  high on the beat carrying address-0 data.
REQ-010 SHALL have port particle_id  output  PARTICLE_ID_WIDTH  ID of the particle whose data is on the memory output this cycle.
REQ-011 SHALL have port ref_id  output  PARTICLE_ID_WIDTH  current reference particle ID.
REQ-012 SHALL have port phase  output  1  sweep phase of the current beat.
REQ-013 SHALL have port prev_phase  output  1  phase of the previous valid beat.
REQ-014 SHALL have port particle_valid  output  1  current beat carries accepted particle data.
REQ-015 SHALL have port busy  output  1  sweep in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at sweep completion.

Function
REQ-017 SHALL assume memory read latency of exactly 1 cycle; memory address 0 holds particle count N, addresses 1..N hold particles, particle ID = address.
REQ-018 SHALL implement FSM IDLE -> READ_NUM -> WAIT_NUM -> SWEEP -> DONE -> IDLE.
REQ-019 IDLE: start=1 moves to READ_NUM and asserts busy next cycle; start while not IDLE SHALL be ignored.
REQ-020 READ_NUM: drive mem_rd_addr=0, mem_rd_en=1; go to WAIT_NUM (stall ignored for count read).
REQ-021 WAIT_NUM: reading_particle_num=1 this cycle only; latch N=count_data; N=0 -> DONE, else -> SWEEP with ref_id=1, phase=0, address=1.
REQ-022 SWEEP: per reference, one phase-0 pass over addresses 1..N then one phase-1 pass over 1..N; address increments only on cycles with stall=0.
REQ-023 At address N accepted in phase 0: next address 1, phase 1; at address N accepted in phase 1: if ref_id==N -> DONE, else ref_id+1, phase 0, address 1.
REQ-024 stall=1: mem_rd_addr, phase, ref_id held; mem_rd_en stays 1; particle_valid=0 next cycle.
REQ-025 particle_id, phase, prev_phase, particle_valid SHALL be registered one cycle after address issue, aligned with memory data.
REQ-026 prev_phase SHALL update to prior phase only on valid beats, so prev_phase=1, phase=0 occurs exactly on the first valid beat of each new reference (never for ref 1).
REQ-027 ref_id output SHALL change on the same beat as the aligned phase 1->0 transition.
REQ-028 DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE; mem_rd_en=0 outside READ_NUM/SWEEP.
REQ-029 Address counter SHALL not wrap; N=2^PARTICLE_ID_WIDTH-1 is the maximum supported count.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE and all outputs 0 (ref_id=0, mem_rd_addr=0), including mid-sweep; no done pulse is generated for an aborted sweep.
REQ-031 After rst_n release, block SHALL wait for a new start.

Verification
REQ-032 N=3, no stall: start -> 1 count beat, 2x3 beats per ref x3 refs = 18 valid beats, particle_id 1,2,3 repeating, done 1 cycle after last beat.
REQ-033 N=0: start -> reading_particle_num pulse, no valid beats, done, busy low.
REQ-034 N=4, stall high 3 cycles mid phase-1 of ref 2 -> address held, 3 invalid beats, sequence resumes without skip/duplicate.
REQ-035 N=2: check prev_phase=1, phase=0, ref_id=2 on first valid beat of ref 2 only.
REQ-036 rst_n low during ref 2 of N=5 -> all outputs 0 immediately; new start replays full sweep from count read.
REQ-037 start pulsed while busy -> ignored, sweep count unchanged.
